reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8; number of architectural registers (power of two, >= 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 36; register width in bits.
REQ-003 SHALL have parameter NUM_RD, default 3; number of independent read ports.
REQ-004 SHALL have derived parameter AW = $clog2(NUM_REGS); address width.
REQ-005 SHALL have port i_clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_rd_addr  input  NUM_RD*AW  packed read addresses; port k in bits [k*AW +: AW].
REQ-008 SHALL have port o_rd_data  output  NUM_RD*DATA_WIDTH  packed read data; port k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port o_rd_busy  output  NUM_RD  per-port flag; high when the addressed register has a pending reservation.
REQ-010 SHALL have port i_wen  input  1  write enable.
REQ-011 SHALL have port i_waddr  input  AW  write address.
REQ-012 SHALL have port i_wdata  input  DATA_WIDTH  write data.
REQ-013 SHALL have port i_rsv_en  input  1  reservation request; marks destination busy at instruction issue.
REQ-014 SHALL have port i_rsv_addr  input  AW  register to reserve.
REQ-015 SHALL have port o_rsv_ack  output  1  combinational; high when the reservation request is accepted this cycle.
REQ-016 SHALL have port o_busy_cnt  output  AW+1  registered count of busy registers.

Function
REQ-017 SHALL keep R0 hardwired: reads of R0 return 0, o_rd_busy for R0 is 0, writes to R0 are discarded.
REQ-018 SHALL make reads combinational, zero-latency, independent per port; ports addressing the same register return identical data.
REQ-019 SHALL update a register with i_wdata on the rising edge when i_wen=1 and i_waddr!=0.
REQ-020 SHALL keep busy[NUM_REGS-1:0], one bit per register; o_rd_busy[k] = busy[addr_k].
REQ-021 SHALL accept a reservation (o_rsv_ack=1) iff i_rsv_en=1 and (i_rsv_addr==0 or busy[i_rsv_addr]==0 or (i_wen=1 and i_waddr==i_rsv_addr)); otherwise o_rsv_ack=0 and no state changes.
REQ-022 SHALL set busy[i_rsv_addr] on the next edge for an accepted reservation with i_rsv_addr!=0; reserving R0 is acked but sets nothing.
REQ-023 SHALL clear busy[i_waddr] on the edge a write to that register occurs, except when an accepted reservation targets the same register in the same cycle, in which case busy ends set (new reservation wins).
REQ-024 SHALL permit writes to a non-busy register; data updates and busy remains 0.
REQ-025 SHALL maintain o_busy_cnt equal to popcount(busy) after every edge; same-cycle set of one register and clear of another leave it unchanged.
REQ-026 SHALL make o_busy_cnt saturation impossible by construction (max NUM_REGS-1, since R0 is never busy).

Reset
REQ-027 SHALL, on a rising edge with i_rst=1, clear all registers to 0, all busy bits to 0 and o_busy_cnt to 0, overriding any same-cycle write or reservation.
REQ-028 SHALL drop any reservation pending when reset asserts; no write is implied afterwards.
REQ-029 SHALL hold o_rsv_ack at 0 while i_rst=1.

Configuration
REQ-030 SHALL compile write-to-read bypass when macro REG_FILE_SB_BYPASS_EN is defined: a read port addressing i_waddr (non-zero) while i_wen=1 returns i_wdata and o_rd_busy=0 that cycle.
REQ-031 SHALL, without REG_FILE_SB_BYPASS_EN, return the pre-write register value and current busy bit during a same-cycle write; new value visible the following cycle.

Verification
REQ-032 SHALL cover: reset, then read R0..R7 on all ports -> all data 0, o_rd_busy=0, o_busy_cnt=0.
REQ-033 SHALL cover: rsv R3, next cycle rsv R3 again -> first ack=1, second ack=0; o_rd_busy=1 for port reading R3; o_busy_cnt=1.
REQ-034 SHALL cover: R3 busy, same cycle write R3=0x123456789 and rsv R3 -> ack=1, R3=0x123456789, busy[3] stays 1, o_busy_cnt=1.
REQ-035 SHALL cover: write R0=0xFFFFFFFFF, rsv R0 -> R0 reads 0, ack=1, o_busy_cnt unchanged.
REQ-036 SHALL cover: write R5=0xABC while port 2 reads R5 -> 0xABC same cycle with REG_FILE_SB_BYPASS_EN, old value without; 0xABC next cycle in both builds.
REQ-037 SHALL cover: rsv R2,R4,R6 over 3 cycles then i_rst=1 with i_wen=1 to R2 -> after edge all busy 0, o_busy_cnt=0, R2 reads 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with a per-register busy scoreboard.
//
// R0 is hardwired to zero and can never be busy. A reservation marks its
// destination busy at issue; the write that later delivers the result clears
// the bit again, unless a new reservation to the same register arrives in the
// same cycle, in which case the register stays busy for the newer producer.
//
// Optional feature: define REG_FILE_SB_BYPASS_EN to forward same-cycle write
// data (and a cleared busy flag) to any read port addressing the write target.
// Without it, reads see the pre-write contents until the following cycle.
module reg_file_sb #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 36,
  parameter int NUM_RD     = 3,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_RD*AW-1:0]           i_rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]              o_rd_busy,
  input  logic                           i_wen,
  input  logic [AW-1:0]                  i_waddr,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic                           i_rsv_en,
  input  logic [AW-1:0]                  i_rsv_addr,
  output logic                           o_rsv_ack,
  output logic [AW:0]                    o_busy_cnt
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [AW:0]           busy_cnt;

  logic wr_hit;     // write that actually lands (non-zero target)
  logic rsv_set;    // accepted reservation that marks a real register
  logic set_new;    // reservation turns a clear bit into a set bit
  logic clr_eff;    // write turns a set bit into a clear bit

  assign wr_hit = i_wen && (i_waddr != '0);

  // A busy register may still be re-reserved when its result is being
  // written back this very cycle: the old producer retires as the new one
  // issues, so the slot is effectively free.
  assign o_rsv_ack = i_rsv_en && !i_rst &&
                     ((i_rsv_addr == '0) || !busy[i_rsv_addr] ||
                      (i_wen && (i_waddr == i_rsv_addr)));

  assign rsv_set = o_rsv_ack && (i_rsv_addr != '0);

  // Count deltas are derived from actual bit transitions so the counter
  // always tracks popcount(busy), including the reserve-and-write-same-reg
  // case where the bit simply stays set.
  assign set_new = rsv_set && !busy[i_rsv_addr];
  assign clr_eff = wr_hit && busy[i_waddr] &&
                   !(rsv_set && (i_rsv_addr == i_waddr));

  // Next busy vector: write-back clears first, then a reservation sets, so a
  // same-cycle reservation of the written register wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_hit) begin
      busy_nxt[i_waddr] = 1'b0;
    end
    if (rsv_set) begin
      busy_nxt[i_rsv_addr] = 1'b1;
    end
  end

  // Scoreboard bits and their running population count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_eff};
    end
  end

  assign o_busy_cnt = busy_cnt;

  // Register storage; R0 is never written so it holds zero after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  // Independent combinational read ports.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          is_r0;
    assign ra    = i_rd_addr[k*AW +: AW];
    assign is_r0 = (ra == '0);
`ifdef REG_FILE_SB_BYPASS_EN
    logic byp;
    assign byp = wr_hit && (ra == i_waddr);
    assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
      is_r0 ? '0 : (byp ? i_wdata : regs[ra]);
    assign o_rd_busy[k] = !is_r0 && !byp && busy[ra];
`else
    assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = is_r0 ? '0 : regs[ra];
    assign o_rd_busy[k] = !is_r0 && busy[ra];
`endif
  end

endmodule
